ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter. Sends one command byte (e.g. 0xFF reset, 0xED set LEDs, 0xF4 enable) from the system to a keyboard or mouse.
- Sits beside the PS2 receiver on the same open-drain clock/data pair.
- Runs the request-to-send sequence, shifts out the frame on device-generated clock edges, checks the device ACK, and reports completion or error.

---
 rtl/ps2_host_tx.sv | 122 ++++++++++++
 tb/tb_ps2_host_tx.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter.
//   clk, rst_n            system clock, async active-low reset
//   data_in, send         command byte and start request (taken in IDLE only)
//   busy, done, ERROR     transfer in progress, end-of-transfer pulse, last status
//   PS2_clk, PS2_dat      pad readback of the open-drain lines
//   PS2_clk_oe, PS2_dat_oe  1 pulls the corresponding line low
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int SETUP_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       send,
  output logic       busy,
  output logic       done,
  output logic       ERROR,
  input  logic       PS2_clk,
  input  logic       PS2_dat,
  output logic       PS2_clk_oe,
  output logic       PS2_dat_oe
);
  localparam int DMAX = INHIBIT_CYCLES > SETUP_CYCLES ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int DW = $clog2(DMAX) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, TX, WAIT_IDLE, DONE} state_t;
  state_t        state_q, state_d;
  logic [1:0]    clk_s_q, dat_s_q;
  logic          clk_p_q;
  logic [7:0]    data_q, data_d;
  logic [3:0]    bit_q, bit_d;
  logic [DW-1:0] dly_q, dly_d;
  logic [TW-1:0] to_q, to_d;
  logic          dat_q, dat_d, err_q, err_d;
  logic          fall;
  assign fall       = clk_p_q & ~clk_s_q[1];
  assign busy       = state_q != IDLE && state_q != DONE;
  assign done       = state_q == DONE;
  assign ERROR      = err_q;
  assign PS2_clk_oe = state_q == INHIBIT || state_q == RTS;
  // dat_q only drives the line while shifting; RTS always holds the start bit
  assign PS2_dat_oe = state_q == RTS || (state_q == TX && dat_q);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      clk_s_q <= 2'b11;
      dat_s_q <= 2'b11;
      clk_p_q <= 1'b1;
      data_q  <= '0;
      bit_q   <= '0;
      dly_q   <= '0;
      to_q    <= '0;
      dat_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      clk_s_q <= {clk_s_q[0], PS2_clk};
      dat_s_q <= {dat_s_q[0], PS2_dat};
      clk_p_q <= clk_s_q[1];
      data_q  <= data_d;
      bit_q   <= bit_d;
      dly_q   <= dly_d;
      to_q    <= to_d;
      dat_q   <= dat_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    bit_d   = bit_q;
    dly_d   = dly_q;
    to_d    = to_q;
    dat_d   = dat_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (send) begin
        data_d  = data_in;
        err_d   = 1'b0;
        dly_d   = '0;
        state_d = INHIBIT;
      end
      INHIBIT: begin
        dly_d = dly_q + 1'b1;
        if (dly_q == DW'(INHIBIT_CYCLES - 1)) begin
          dly_d   = '0;
          state_d = RTS;
        end
      end
      RTS: begin
        dly_d = dly_q + 1'b1;
        if (dly_q == DW'(SETUP_CYCLES - 1)) begin
          bit_d   = '0;
          to_d    = '0;
          dat_d   = 1'b1;
          state_d = TX;
        end
      end
      TX, WAIT_IDLE: begin
        to_d = to_q + 1'b1;
        if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          dat_d   = 1'b0;
          state_d = DONE;
        end else if (state_q == WAIT_IDLE) begin
          state_d = clk_s_q[1] && dat_s_q[1] ? DONE : WAIT_IDLE;
        end else if (fall) begin
          bit_d = bit_q + 1'b1;
          // ~parity of odd parity equals the plain XOR of the byte
          dat_d = bit_q < 4'd8 ? ~data_q[bit_q[2:0]] : bit_q == 4'd8 ? ^data_q : 1'b0;
          if (bit_q == 4'd10) begin
            err_d   = dat_s_q[1];
            state_d = WAIT_IDLE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized device-model bench for ps2_host_tx.
module tb_ps2_host_tx;
  localparam int INH  = 40;
  localparam int SET  = 6;
  localparam int TMO  = 2000;
  localparam int HALF = 20;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_in = '0;
  logic       send = 1'b0;
  logic       busy, done, ERROR, clk_oe, dat_oe;
  logic       dev_clk = 1'b1, dev_dat = 1'b1;
  logic       ps2_clk, ps2_dat;
  int         total = 0, bad = 0;
  assign ps2_clk = ~clk_oe & dev_clk;
  assign ps2_dat = ~dat_oe & dev_dat;
  always #5 clk = ~clk;
  ps2_host_tx #(.INHIBIT_CYCLES(INH), .SETUP_CYCLES(SET), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .send(send), .busy(busy),
    .done(done), .ERROR(ERROR), .PS2_clk(ps2_clk), .PS2_dat(ps2_dat),
    .PS2_clk_oe(clk_oe), .PS2_dat_oe(dat_oe)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [9:0] frame_of(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d};
  endfunction
  task automatic do_send(input logic [7:0] b);
    int n;
    @(negedge clk);
    data_in = b;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    n = 1;
    chk("busy_after_send", busy, 1);
    while (clk_oe && n < 4 * (INH + SET)) begin
      @(negedge clk);
      n++;
    end
    chk("release_latency", n, INH + SET + 1);
  endtask
  task automatic dev_run(input bit ack, input int n_edges, input int poke,
                         output logic st, output logic [9:0] seen);
    seen = '0;
    repeat (HALF / 2) @(negedge clk);
    st = ps2_dat;
    for (int k = 1; k <= n_edges; k++) begin
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b0;
      if (k == poke) begin
        send = 1'b1;
        data_in = 8'h34;
        @(negedge clk);
        send = 1'b0;
      end
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      if (k == 11) dev_dat = 1'b1;
      else begin
        repeat (HALF / 2) @(negedge clk);
        if (k <= 10) seen[k-1] = ps2_dat;
        if (k == 10 && ack) dev_dat = 1'b0;
      end
    end
  endtask
  task automatic xfer_end(input logic exp_err);
    int n = 0;
    while (!done && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", done, 1);
    chk("busy_at_done", busy, 0);
    chk("error", ERROR, exp_err);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
  endtask
  task automatic run_frame(input logic [7:0] b, input bit ack, input int poke);
    logic st;
    logic [9:0] seen;
    do_send(b);
    dev_run(ack, 11, poke, st, seen);
    chk("start_bit", st, 0);
    chk("frame", seen, frame_of(b));
    xfer_end(!ack);
  endtask
  initial begin
    logic st;
    logic [9:0] seen;
    int n;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", ERROR, 0);
    chk("rst_clk_oe", clk_oe, 0);
    chk("rst_dat_oe", dat_oe, 0);
    rst_n = 1'b1;
    run_frame(8'hF4, 1'b1, 0);
    run_frame(8'hFF, 1'b1, 0);
    run_frame(8'hED, 1'b0, 0);
    for (int i = 0; i < 3; i++) run_frame(8'($urandom_range(0, 255)), 1'b1, 0);
    run_frame(8'h12, 1'b1, 5);
    repeat (5) @(negedge clk);
    chk("no_retrigger", busy, 0);
    do_send(8'h55);
    n = 0;
    while (!done && n < 2 * TMO) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycles", n, TMO);
    chk("timeout_error", ERROR, 1);
    chk("timeout_clk_oe", clk_oe, 0);
    chk("timeout_dat_oe", dat_oe, 0);
    do_send(8'hAA);
    dev_run(1'b1, 4, 0, st, seen);
    chk("busy_mid", busy, 1);
    chk("mid_bits", seen[2:0], 3'b010);
    rst_n = 1'b0;
    #1;
    chk("arst_clk_oe", clk_oe, 0);
    chk("arst_dat_oe", dat_oe, 0);
    chk("arst_busy", busy, 0);
    dev_clk = 1'b1;
    dev_dat = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run_frame(8'hAA, 1'b1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
